// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//             7-segment display. Captures the digits once per frame, steps
//             through slots 0..3, inserts an anode-off guard at each digit
//             change and optionally suppresses leading zeros.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(BLANK_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [1:0]           slot_q, slot_d;
  logic [15:0]          snap_q, snap_d;
  logic [3:0]           dps_q, dps_d;
  logic                 bl_q, bl_d;
  logic                 frame_entry_d;

  logic [3:0]           tail_blank_d;
  logic                 suppress_d;
  logic                 lit_d;
  logic [3:0]           digit_d;
  logic [3:0]           an_d;
  logic                 dp_d;

  // Next-state logic: slot sequencing, guard/drive phases and frame snapshot.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    snap_d        = snap_q;
    dps_d         = dps_q;
    bl_d          = bl_q;
    frame_entry_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d       = S_GUARD;
          cnt_d         = '0;
          slot_d        = 2'd0;
          frame_entry_d = 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == c_guard_last) begin
          state_d = S_DRIVE;
        end
        cnt_d = cnt_q + c_cnt_one;
      end
      S_DRIVE: begin
        if (cnt_q == c_cnt_last) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          if (slot_q == 2'd3) begin
            frame_entry_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        slot_d  = 2'd0;
      end
    endcase

    // Dropping enable wins over everything, including a pending frame entry.
    if (!enable) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      slot_d        = 2'd0;
      frame_entry_d = 1'b0;
    end

    if (frame_entry_d) begin
      snap_d = digits_in;
      dps_d  = dp_mask;
      bl_d   = blank_lead;
    end
  end

  // Leading-zero suppression: digit k is blank when it and every higher digit
  // is zero with no decimal point among them; digit 0 always shows.
  always_comb begin
    tail_blank_d[3] = (snap_d[15:12] == 4'h0) && !dps_d[3];
    tail_blank_d[2] = tail_blank_d[3] && (snap_d[11:8] == 4'h0) && !dps_d[2];
    tail_blank_d[1] = tail_blank_d[2] && (snap_d[7:4]  == 4'h0) && !dps_d[1];
    tail_blank_d[0] = 1'b0;
    suppress_d      = bl_d && tail_blank_d[slot_d];
  end

  // Output decode from the next state so that every output is registered.
  always_comb begin
    lit_d   = (state_d == S_DRIVE) && !suppress_d;
    digit_d = (state_d == S_IDLE) ? 4'h0 : snap_d[{slot_d, 2'b00} +: 4];
    an_d    = lit_d ? ~(4'b0001 << slot_d) : 4'b1111;
    dp_d    = lit_d ? ~dps_d[slot_d] : 1'b1;
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= 2'd0;
      snap_q      <= 16'h0000;
      dps_q       <= 4'h0;
      bl_q        <= 1'b0;
      digit_out   <= 4'h0;
      an          <= 4'b1111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      snap_q      <= snap_d;
      dps_q       <= dps_d;
      bl_q        <= bl_d;
      digit_out   <= digit_d;
      an          <= an_d;
      dp          <= dp_d;
      frame_start <= frame_entry_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

- Time-multiplexed scan controller for the stopwatch's 4-digit common-anode 7-segment display.
- Snapshots four BCD digits once per frame and steps through the digits one slot at a time.
- Per slot, drives the selected digit code to the combinational BCD-to-7-segment decoder, plus the active-low anode and decimal-point lines.
- Inserts a blanking guard at each digit change to suppress ghosting, and optionally blanks leading zeros.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot. Legal range is 2..2^20.
- `BLANK_CYCLES`, default 1000: guard cycles at the start of each slot, with all anodes off. Legal range is 1..REFRESH_DIV-1.
- `clk`  in  1: system clock, the single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: scanning enabled. Low blanks the display.
- `digits_in`  in  16: four BCD digits. Digit k is bits [4k+3:4k]; digit 0 is the rightmost.
- `dp_mask`  in  4: bit k lights the decimal point of digit k.
- `blank_lead`  in  1: enables leading-zero blanking.
- `digit_out`  out  4: BCD code for the decoder input.
- `an`  out  4: anode enables, active-low. Bit k selects digit k.
- `dp`  out  1: decimal point, active-low.
- `frame_start`  out  1: one-cycle pulse when slot 0 begins.

## Operation
- **States:**
  - IDLE: display off.
  - GUARD: anodes off; digit_out already showing the new digit.
  - DRIVE: the selected anode is on.
- **Counters:**
  - `cnt`, 0..REFRESH_DIV-1, counts cycles within a slot.
  - `slot`, 0..3, scans in the order 0, 1, 2, 3, then wraps to 0.
- **IDLE to GUARD:** on `enable` high, with `slot`=0 and `cnt`=0, and a snapshot is captured.
- **GUARD to DRIVE:** when `cnt` reaches BLANK_CYCLES.
- **End of slot:** at `cnt`=REFRESH_DIV-1 the controller returns to GUARD, `slot` increments, and `cnt` is cleared.
- **Snapshot:** `digits_in`, `dp_mask` and `blank_lead` are latched only on entry to slot 0. Input changes mid-frame are invisible until the next frame, so the display never tears.
- **Leading-zero blanking:** applies only when the snapshotted `blank_lead` is 1. Digit k (k≥1) is suppressed when both of these hold:
  - digits k..3 are all 0;
  - no `dp_mask` bit among k..3 is set.
  - Digit 0 is never suppressed.
- **Suppressed digit:** `an` and `dp` stay high for the whole slot; `digit_out` still carries the code.
- **DRIVE outputs for slot k:**
  - `an` = ~(1<<k);
  - `dp` = ~dp_mask_snap[k];
  - `digit_out` = snap[k].
- **Outside DRIVE:**
  - `an`=4'b1111 and `dp`=1.
  - In GUARD, `digit_out` = snap[slot].
  - In IDLE, `digit_out` = 0.
- **Non-BCD codes (10–15)** pass through unmodified. Decoding them is the decoder's responsibility.
- **Enable low:**
  - Takes effect at the next edge in any state: go to IDLE, clear the counters, all outputs to their reset values.
  - Re-enabling always restarts at slot 0 with a fresh snapshot.

## Timing
- All outputs are registered.
- Reset values: `an`=4'b1111, `dp`=1, `digit_out`=4'h0, `frame_start`=0, state IDLE, `cnt`=0, `slot`=0, snapshot cleared.
- Reset asserted mid-scan forces the reset values immediately, asynchronously.
- **Startup:** if `enable` is sampled high at edge E, the outputs after E are:
  - state GUARD;
  - `digit_out` = `digits_in`[3:0] as sampled at E;
  - `frame_start`=1 for exactly one cycle.
- **Per-slot timing:**
  - The anode asserts BLANK_CYCLES cycles after slot entry.
  - The anode stays low for REFRESH_DIV-BLANK_CYCLES cycles.
  - One full frame is 4×REFRESH_DIV cycles.
- **frame_start:** pulses in the first cycle of every slot 0 (every 4×REFRESH_DIV cycles while enabled).
- **Simultaneous events:**
  - A `digits_in` change on the same edge as a slot-0 entry is captured.
  - If `enable` falls on the cycle slot 0 would begin, the controller goes to IDLE: no `frame_start` pulse and no snapshot.
- At no cycle is more than one `an` bit low.
- An anode bit never goes low in the same cycle that `digit_out` changes.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2.

- **Reset:** assert `rst_n`=0 mid-DRIVE → same cycle `an`=1111, `dp`=1, `digit_out`=0. Release with `enable`=1 → `frame_start` pulses one edge later.
- **Basic scan:** `digits_in`=16'h1234, `dp_mask`=0100, `blank_lead`=0 → for each slot:
  - the codes in order are 4, 3, 2, 1;
  - `an` sequence is 1110, 1101, 1011, 0111, each low for 6 cycles after 2 guard cycles;
  - `dp`=0 only during slot 2 DRIVE;
  - `frame_start` period is 32 cycles.
- **Leading-zero blanking:** `digits_in`=16'h0050, `blank_lead`=1, `dp_mask`=0 → `an` is low only in slots 0 and 1; slots 2 and 3 stay 1111. With `dp_mask`=1000, all four slots drive.
- **Snapshot coherency:** change `digits_in` from 16'h1234 to 16'h9876 during slot 1 → remainder of that frame shows 3, 2, 1; the next frame shows 6, 7, 8, 9.
- **Enable toggle:** drop `enable` during slot 2 DRIVE → next edge `an`=1111, state IDLE. Raise `enable` → restart at slot 0 with `frame_start`=1.
- **Invariants (checked throughout all runs):**
  - popcount(~`an`) ≤ 1 every cycle;
  - `digit_out` is stable whenever an anode is low;
  - a non-BCD input of 16'hA000 passes code A to `digit_out` in slot 3.
